dpram_burst_master: RTL and testbench

DPRAM_BURST_MASTER -- requirements
Module: dpram_burst_master

---
 rtl/dpram_burst_master.sv | 130 +++++++++++++
 tb/tb_dpram_burst_master.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_master.sv
// dpram_burst_master
// Turns write/read burst commands into single-beat strobes on one port of a
// true dual-port RAM. Writes stream straight through with no added latency;
// reads keep at most one access in flight so rd_data can be held under
// backpressure without a skid buffer.
module dpram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  // write beat stream
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  // read beat stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  // status
  output logic                  busy,
  output logic                  done,
  // RAM port
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  beats_left;  // beats still to issue, minus one
  logic                  dir;         // 1 = write burst
  logic                  pending;     // read strobe issued, data lands this cycle
  logic                  issued_all;  // final beat of the burst has been issued
  logic                  rd_valid_q;

  logic cmd_accept, wr_beat, rd_strobe, rd_hs, last_beat;

  // Handshakes; every externally visible strobe is killed while rst is high.
  assign cmd_ready  = (state == IDLE) && !rst;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign wr_ready   = (state == WRITE) && dir && !rst;
  assign wr_beat    = wr_ready && wr_valid;
  assign rd_valid   = rd_valid_q && !rst;
  assign rd_hs      = rd_valid && rd_ready;
  assign last_beat  = (beats_left == '0);

  // A new read may go out only when nothing is in flight and the output
  // register is empty or being drained this very cycle.
  assign rd_strobe = (state == READ) && !dir && !rst && !pending &&
                     !issued_all && (!rd_valid_q || rd_ready);

  assign ram_en    = wr_beat || rd_strobe;
  assign ram_we    = wr_beat;
  assign ram_addr  = cur_addr;
  assign ram_wdata = wr_data;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next-state logic: a read burst ends on the handshake of its last beat,
  // which is the only beat outstanding once issued_all is set.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_accept) state_nx = cmd_write ? WRITE : READ;
      WRITE:   if (wr_beat && last_beat) state_nx = DONE;
      READ:    if (rd_hs && issued_all) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Burst bookkeeping: latch the command, then step address and count per issued beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      dir        <= 1'b0;
      issued_all <= 1'b0;
    end else if (cmd_accept) begin
      cur_addr   <= cmd_addr;
      beats_left <= cmd_len;
      dir        <= cmd_write;
      issued_all <= 1'b0;
    end else if (wr_beat || rd_strobe) begin
      cur_addr <= cur_addr + 1'b1;
      if (last_beat) issued_all <= 1'b1;
      else           beats_left <= beats_left - 1'b1;
    end
  end

  // Read return path: capture RAM data the cycle after the strobe and hold
  // it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data    <= '0;
    end else begin
      pending <= rd_strobe;
      if (pending) begin
        rd_data    <= ram_rdata;
        rd_valid_q <= 1'b1;
      end else if (rd_hs) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_burst_master.sv
// Bench for dpram_burst_master: directed burst scenarios plus randomized
// bursts checked against a reference memory image and the beat-timing rules.
module tb_dpram_burst_master;
  localparam int DW = 8, AW = 8, LW = 4, MAXC = 200;

  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic wr_valid, wr_ready, rd_valid, rd_ready, busy, done, ram_en, ram_we;
  logic [DW-1:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  dpram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clk = ~clk;

  // RAM port seen by the DUT (environment, not the reference).
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  // Reference memory image and bookkeeping.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wq [16];
  int n_cmp = 0, n_err = 0;

  // Per-cycle recording of one burst; cycle 0 = first cycle after accept.
  logic rec_en[MAXC], rec_we[MAXC], rec_wrdy[MAXC], rec_vld[MAXC];
  logic rec_rdy[MAXC], rec_done[MAXC], rec_busy[MAXC], rec_cr[MAXC];
  logic [DW-1:0] rec_rdata[MAXC];
  int rec_n;
  int s_cyc[$], b_cyc[$], d_cyc[$];
  logic [AW-1:0] s_addr[$];
  logic s_we[$];
  logic [DW-1:0] s_wdata[$], b_data[$];

  // Stimulus and observation of one burst. mode: 0 = always valid/ready,
  // 1 = rd_ready low for the first 5 rd_valid cycles, 2 = random.
  task automatic run_burst(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode);
    int k, vcnt, tail;
    k = 0; vcnt = 0; tail = -1;
    s_cyc.delete(); s_addr.delete(); s_we.delete(); s_wdata.delete();
    b_cyc.delete(); b_data.delete(); d_cyc.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 4'($urandom);
    rec_n = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) @(negedge clk);
      wr_valid = wr && (mode == 0 || $urandom_range(0, 2) != 0);
      wr_data  = (k < 16) ? wq[k] : 8'h00;
      rd_ready = !wr && (mode == 0 || (mode == 1 && vcnt >= 5) ||
                         (mode == 2 && $urandom_range(0, 2) != 0));
      #1;
      rec_en[c] = ram_en; rec_we[c] = ram_we; rec_wrdy[c] = wr_ready;
      rec_vld[c] = rd_valid; rec_rdy[c] = rd_ready; rec_done[c] = done;
      rec_busy[c] = busy; rec_cr[c] = cmd_ready; rec_rdata[c] = rd_data;
      if (ram_en) begin
        s_cyc.push_back(c); s_addr.push_back(ram_addr);
        s_we.push_back(ram_we); s_wdata.push_back(ram_wdata);
      end
      if (rd_valid && rd_ready) begin b_cyc.push_back(c); b_data.push_back(rd_data); end
      if (done) d_cyc.push_back(c);
      if (wr_valid && wr_ready) k++;
      if (rd_valid) vcnt++;
      rec_n = c + 1;
      if (done && tail < 0) tail = c;
      if (tail >= 0 && c > tail) break;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({cmd_ready, ram_en, ram_we, wr_ready, rd_valid} !== 5'b0) begin
      n_err++; $display("FAIL reset_forced_low: got %b want 00000", {cmd_ready, ram_en, ram_we, wr_ready, rd_valid});
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++;
    if ({busy, done, rd_valid, ram_en} !== 4'b0) begin
      n_err++; $display("FAIL reset_status: busy/done/rd_valid/ram_en got %b want 0000", {busy, done, rd_valid, ram_en});
    end
    n_cmp++;
    if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
  endtask

  task automatic test_write_basic();
    int bad;
    for (int k = 0; k < 4; k++) wq[k] = 8'(8'hA0 + k);
    run_burst(1'b1, 8'h10, 4'd3, 0);
    n_cmp++;
    if (s_cyc.size() != 4) begin n_err++; $display("FAIL wr_basic_nstrobe: got %0d want 4", s_cyc.size()); end
    for (int k = 0; k < s_cyc.size() && k < 4; k++) begin
      n_cmp++;
      if (s_cyc[k] != k || s_addr[k] !== 8'(8'h10 + k) || s_we[k] !== 1'b1 || s_wdata[k] !== wq[k]) begin
        n_err++;
        $display("FAIL wr_basic_beat%0d: got cyc %0d addr %0h we %b data %0h want cyc %0d addr %0h we 1 data %0h",
                 k, s_cyc[k], s_addr[k], s_we[k], s_wdata[k], k, 8'(8'h10 + k), wq[k]);
      end
    end
    for (int k = 0; k < 4; k++) ref_mem[8'(8'h10 + k)] = wq[k];
    n_cmp++;
    if (d_cyc.size() != 1 || d_cyc[0] != 4) begin
      n_err++; $display("FAIL wr_basic_done: got %0d pulses first at %0d want 1 at 4", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1);
    end
    n_cmp++;
    if (rec_n < 6 || rec_cr[4] !== 1'b0 || rec_cr[5] !== 1'b1) begin
      n_err++; $display("FAIL wr_basic_cmd_ready: got done-cycle %b next %b want 0 then 1", rec_cr[4], rec_cr[5]);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) if (rec_busy[c] !== 1'b1) bad++;
    if (rec_busy[5] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL wr_basic_busy: got %0d wrong cycles want 0", bad); end
  endtask

  task automatic test_read_basic();
    int nv;
    run_burst(1'b0, 8'h10, 4'd3, 0);
    n_cmp++;
    if (s_cyc.size() != 4) begin n_err++; $display("FAIL rd_basic_nstrobe: got %0d want 4", s_cyc.size()); end
    for (int k = 0; k < s_cyc.size() && k < 4; k++) begin
      n_cmp++;
      if (s_cyc[k] != 2 * k || s_addr[k] !== 8'(8'h10 + k) || s_we[k] !== 1'b0) begin
        n_err++; $display("FAIL rd_basic_strobe%0d: got cyc %0d addr %0h we %b want cyc %0d addr %0h we 0",
                          k, s_cyc[k], s_addr[k], s_we[k], 2 * k, 8'(8'h10 + k));
      end
    end
    n_cmp++;
    if (b_cyc.size() != 4) begin n_err++; $display("FAIL rd_basic_nbeat: got %0d want 4", b_cyc.size()); end
    for (int k = 0; k < b_cyc.size() && k < 4; k++) begin
      n_cmp++;
      if (b_cyc[k] != 2 * k + 2 || b_data[k] !== ref_mem[8'(8'h10 + k)]) begin
        n_err++; $display("FAIL rd_basic_beat%0d: got cyc %0d data %0h want cyc %0d data %0h",
                          k, b_cyc[k], b_data[k], 2 * k + 2, ref_mem[8'(8'h10 + k)]);
      end
    end
    nv = 0;
    for (int c = 0; c < rec_n; c++) if (rec_vld[c]) nv++;
    n_cmp++;
    if (nv != 4) begin n_err++; $display("FAIL rd_basic_valid_cycles: got %0d want 4", nv); end
    n_cmp++;
    if (d_cyc.size() != 1 || d_cyc[0] != 9) begin
      n_err++; $display("FAIL rd_basic_done: got %0d pulses first at %0d want 1 at 9", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [3];
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    for (int k = 0; k < 3; k++) wq[k] = 8'($urandom);
    run_burst(1'b1, 8'hFE, 4'd2, 0);
    n_cmp++;
    if (s_cyc.size() != 3) begin n_err++; $display("FAIL wrap_nstrobe: got %0d want 3", s_cyc.size()); end
    for (int k = 0; k < s_cyc.size() && k < 3; k++) begin
      n_cmp++;
      if (s_addr[k] !== ea[k] || s_wdata[k] !== wq[k] || s_we[k] !== 1'b1) begin
        n_err++; $display("FAIL wrap_beat%0d: got addr %0h data %0h want addr %0h data %0h", k, s_addr[k], s_wdata[k], ea[k], wq[k]);
      end
    end
    for (int k = 0; k < 3; k++) ref_mem[ea[k]] = wq[k];
    n_cmp++;
    if (d_cyc.size() != 1 || d_cyc[0] != 3) begin n_err++; $display("FAIL wrap_done: got %0d pulses want 1 at 3", d_cyc.size()); end
  endtask

  task automatic test_read_stall();
    int es [4];
    int eb [4];
    es = '{0, 7, 9, 11};
    eb = '{7, 9, 11, 13};
    run_burst(1'b0, 8'h10, 4'd3, 1);
    for (int c = 2; c <= 6; c++) begin
      n_cmp++;
      if (rec_vld[c] !== 1'b1 || rec_en[c] !== 1'b0 || rec_rdata[c] !== ref_mem[8'h10]) begin
        n_err++; $display("FAIL stall_hold_c%0d: got vld %b en %b data %0h want vld 1 en 0 data %0h",
                          c, rec_vld[c], rec_en[c], rec_rdata[c], ref_mem[8'h10]);
      end
    end
    n_cmp++;
    if (s_cyc.size() != 4 || b_cyc.size() != 4) begin
      n_err++; $display("FAIL stall_counts: got %0d strobes %0d beats want 4 and 4", s_cyc.size(), b_cyc.size());
    end
    for (int k = 0; k < 4 && k < s_cyc.size() && k < b_cyc.size(); k++) begin
      n_cmp++;
      if (s_cyc[k] != es[k] || b_cyc[k] != eb[k] || s_addr[k] !== 8'(8'h10 + k) || b_data[k] !== ref_mem[8'(8'h10 + k)]) begin
        n_err++; $display("FAIL stall_beat%0d: got strobe %0d hs %0d addr %0h data %0h want %0d %0d %0h %0h",
                          k, s_cyc[k], b_cyc[k], s_addr[k], b_data[k], es[k], eb[k], 8'(8'h10 + k), ref_mem[8'(8'h10 + k)]);
      end
    end
    n_cmp++;
    if (d_cyc.size() != 1 || d_cyc[0] != 14) begin n_err++; $display("FAIL stall_done: got %0d pulses want 1 at 14", d_cyc.size()); end
  endtask

  task automatic test_len0_read();
    int nv;
    run_burst(1'b0, 8'h12, 4'd0, 0);
    n_cmp++;
    if (s_cyc.size() != 1 || s_cyc[0] != 0 || s_addr[0] !== 8'h12) begin
      n_err++; $display("FAIL len0_strobe: got %0d strobes want 1 at cycle 0 addr 12", s_cyc.size());
    end
    nv = 0;
    for (int c = 0; c < rec_n; c++) if (rec_vld[c]) nv++;
    n_cmp++;
    if (nv != 1 || b_cyc.size() != 1 || b_data[0] !== ref_mem[8'h12]) begin
      n_err++; $display("FAIL len0_beat: got %0d valid cycles data %0h want 1 data %0h", nv, b_data.size() > 0 ? b_data[0] : 8'h00, ref_mem[8'h12]);
    end
    n_cmp++;
    if (d_cyc.size() != 1 || b_cyc.size() != 1 || d_cyc[0] != b_cyc[0] + 1) begin
      n_err++; $display("FAIL len0_done: got %0d pulses want 1 the cycle after the handshake", d_cyc.size());
    end
  endtask

  task automatic test_random();
    bit wr;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int n, viol;
    for (int op = 0; op < 40; op++) begin
      // first 16 ops fill the whole RAM so every later read has a known value
      if (op < 16) begin wr = 1'b1; a = 8'(op * 16); l = 4'hF; end
      else begin wr = 1'($urandom); a = 8'($urandom); l = 4'($urandom); end
      n = int'(l) + 1;
      for (int k = 0; k < 16; k++) wq[k] = 8'($urandom);
      run_burst(wr, a, l, wr ? 2 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)));
      n_cmp++;
      if (s_cyc.size() != n) begin n_err++; $display("FAIL rand%0d_nstrobe: got %0d want %0d", op, s_cyc.size(), n); end
      for (int k = 0; k < s_cyc.size() && k < n; k++) begin
        n_cmp++;
        if (s_addr[k] !== 8'(int'(a) + k) || s_we[k] !== wr || (wr && s_wdata[k] !== wq[k])) begin
          n_err++; $display("FAIL rand%0d_strobe%0d: got addr %0h we %b data %0h want addr %0h we %b data %0h",
                            op, k, s_addr[k], s_we[k], s_wdata[k], 8'(int'(a) + k), wr, wq[k]);
        end
      end
      if (wr) begin
        for (int k = 0; k < n; k++) ref_mem[8'(int'(a) + k)] = wq[k];
        n_cmp++;
        if (d_cyc.size() != 1 || s_cyc.size() != n || d_cyc[0] != s_cyc[n - 1] + 1) begin
          n_err++; $display("FAIL rand%0d_wr_done: got %0d pulses want 1 after last beat", op, d_cyc.size());
        end
      end else begin
        n_cmp++;
        if (b_data.size() != n) begin n_err++; $display("FAIL rand%0d_nbeat: got %0d want %0d", op, b_data.size(), n); end
        for (int k = 0; k < b_data.size() && k < n; k++) begin
          n_cmp++;
          if (b_data[k] !== ref_mem[8'(int'(a) + k)]) begin
            n_err++; $display("FAIL rand%0d_data%0d: got %0h want %0h", op, k, b_data[k], ref_mem[8'(int'(a) + k)]);
          end
        end
        n_cmp++;
        if (d_cyc.size() != 1 || b_cyc.size() != n || d_cyc[0] != b_cyc[n - 1] + 1) begin
          n_err++; $display("FAIL rand%0d_rd_done: got %0d pulses want 1 after last handshake", op, d_cyc.size());
        end
      end
      viol = 0;
      for (int c = 0; c < rec_n; c++) begin
        if (rec_we[c] && !rec_en[c]) viol++;
        if (wr ? rec_vld[c] : rec_wrdy[c]) viol++;
        if (rec_done[c] && (rec_en[c] || rec_wrdy[c] || rec_vld[c] || rec_cr[c])) viol++;
        if (c + 1 < rec_n && rec_vld[c] && !rec_rdy[c] && (!rec_vld[c + 1] || rec_rdata[c + 1] !== rec_rdata[c])) viol++;
      end
      n_cmp++;
      if (viol != 0) begin n_err++; $display("FAIL rand%0d_protocol: got %0d violations want 0", op, viol); end
    end
  endtask

  task automatic test_reset_abort();
    int dn;
    dn = 0;
    // beats 4..7 differ from the RAM so a stray write would show on read-back
    for (int k = 0; k < 8; k++) wq[k] = (k < 4) ? 8'($urandom) : ~ref_mem[8'(8'h40 + k)];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      wr_valid = 1'b1; wr_data = wq[k];
      #1;
      n_cmp++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'(8'h40 + k)) begin
        n_err++; $display("FAIL abort_beat%0d: got en %b we %b addr %0h want 1 1 %0h", k, ram_en, ram_we, ram_addr, 8'(8'h40 + k));
      end
      if (done) dn++;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; wr_data = wq[4 + c];
      #1;
      n_cmp++;
      if ({ram_en, ram_we, wr_ready, cmd_ready, rd_valid} !== 5'b0) begin
        n_err++; $display("FAIL abort_in_reset%0d: got %b want 00000", c, {ram_en, ram_we, wr_ready, cmd_ready, rd_valid});
      end
      if (done) dn++;
    end
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_after_reset: got cmd_ready %b busy %b want 1 0", cmd_ready, busy);
    end
    if (done) dn++;
    @(negedge clk);
    #1;
    if (done) dn++;
    n_cmp++;
    if (dn != 0) begin n_err++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
    for (int k = 0; k < 4; k++) ref_mem[8'(8'h40 + k)] = wq[k];
    run_burst(1'b0, 8'h40, 4'd7, 0);
    n_cmp++;
    if (b_data.size() != 8) begin n_err++; $display("FAIL abort_readback_n: got %0d want 8", b_data.size()); end
    for (int k = 0; k < b_data.size() && k < 8; k++) begin
      n_cmp++;
      if (b_data[k] !== ref_mem[8'(8'h40 + k)]) begin
        n_err++; $display("FAIL abort_readback%0d: got %0h want %0h", k, b_data[k], ref_mem[8'(8'h40 + k)]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_read_stall();
    test_len0_read();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
